// File: rtl/nonce_verifier.sv
// nonce_verifier: consumer-side check of a (block, nonce) pair against a
// difficulty target, using the mining micro-hash. Iterative engine: one
// hash round per cycle, 32 rounds per check. Keeps saturating statistics.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. A producer holds valid (and its payload) until that
// edge; ready never depends combinationally on valid.
//   request : req_valid/req_ready  (payload data_in, nonce, target)
//   response: resp_valid/resp_ready (payload pass, hash_out)
`timescale 1ns/1ps

module nonce_verifier #(
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [12*BYTE_W-1:0]  data_in,
    input  logic [4*BYTE_W-1:0]   nonce,
    input  logic [BYTE_W-1:0]     target,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  pass,
    output logic [3*BYTE_W-1:0]   hash_out,
    output logic [CNT_W-1:0]      checked_cnt,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HASH  = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [BYTE_W-1:0] H0_INIT = BYTE_W'(8'h01);
    localparam logic [BYTE_W-1:0] H1_INIT = BYTE_W'(8'h89);
    localparam logic [BYTE_W-1:0] H2_INIT = BYTE_W'(8'hFE);
    localparam logic [BYTE_W-1:0] K_LO    = BYTE_W'(8'h99);
    localparam logic [BYTE_W-1:0] K_HI    = BYTE_W'(8'hA1);
    localparam logic [4:0]        LAST_RD = 5'd31;
    localparam logic [4:0]        K_SWAP  = 5'd16;

    state_t            state;
    logic [4:0]        round;
    logic [BYTE_W-1:0] win [16];
    logic [BYTE_W-1:0] target_q;
    logic [BYTE_W-1:0] h0, h1, h2;

    // Per-round combinational terms
    logic [BYTE_W-1:0] k_sel;
    logic [BYTE_W-1:0] x_sel;
    logic [BYTE_W-1:0] h0_next;
    logic [BYTE_W-1:0] h1_next;
    logic [BYTE_W-1:0] h2_next;
    logic [BYTE_W-1:0] w_new;
    logic              pass_now;

    assign dbg_state = state;

    // Round function, next schedule byte and acceptance compare
    always_comb begin
        k_sel    = K_LO;
        x_sel    = h1 ^ h2;
        if (round > K_SWAP) begin
            k_sel = K_HI;
            x_sel = h0 ^ h1;
        end
        // win[j] holds W[round+j]; W[round+16] = W[round+13] | (W[round+7] ^ W[round+2])
        w_new    = win[13] | (win[7] ^ win[2]);
        h0_next  = h2 + (x_sel ^ win[0]) + k_sel;
        h1_next  = {h0[BYTE_W-2:0], h0[BYTE_W-1]};
        h2_next  = {h1[1:0], h1[BYTE_W-1:2]};
        pass_now = (h0 < target_q) && (h1 < target_q);
    end

    // Control FSM with registered handshake outputs, datapath and statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            round       <= '0;
            target_q    <= '0;
            h0          <= '0;
            h1          <= '0;
            h2          <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            pass        <= 1'b0;
            hash_out    <= '0;
            checked_cnt <= '0;
            pass_cnt    <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        // Message bytes 0..11 from data_in (MSB first), 12..15 from nonce
                        for (int i = 0; i < 12; i++) begin
                            win[i] <= data_in[(12-i)*BYTE_W-1 -: BYTE_W];
                        end
                        for (int i = 0; i < 4; i++) begin
                            win[12+i] <= nonce[(4-i)*BYTE_W-1 -: BYTE_W];
                        end
                        target_q  <= target;
                        h0        <= H0_INIT;
                        h1        <= H1_INIT;
                        h2        <= H2_INIT;
                        round     <= '0;
                        req_ready <= 1'b0;
                        state     <= HASH;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                HASH: begin
                    h0 <= h0_next;
                    h1 <= h1_next;
                    h2 <= h2_next;
                    // Consume W[round], append W[round+16]
                    for (int i = 0; i < 15; i++) begin
                        win[i] <= win[i+1];
                    end
                    win[15] <= w_new;
                    round   <= round + 5'd1;
                    if (round == LAST_RD) begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    pass     <= pass_now;
                    hash_out <= {h0, h1, h2};
                    if (checked_cnt != {CNT_W{1'b1}}) begin
                        checked_cnt <= checked_cnt + 1'b1;
                    end
                    if (pass_now && (pass_cnt != {CNT_W{1'b1}})) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end

                RESP: begin
                    // Response held until consumed; the next request waits for this
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_verifier.sv
// tb_nonce_verifier: directed and random checks of nonce_verifier against a
// bench-side model of the micro-hash built from the full 32-byte schedule.
`timescale 1ns/1ps

module tb_nonce_verifier;

    localparam int CNT_W = 4;
    localparam int EXP_W = 1 + 24 + 2*CNT_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [95:0]       data_in = '0;
    logic [31:0]       nonce = '0;
    logic [7:0]        target = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic              pass;
    logic [23:0]       hash_out;
    logic [CNT_W-1:0]  checked_cnt;
    logic [CNT_W-1:0]  pass_cnt;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    // scoreboard: {pass, hash, checked_cnt, pass_cnt} per accepted request
    logic [EXP_W-1:0] exp_q[$];
    int               m_chk = 0;
    int               m_pcnt = 0;
    logic             cur_pass = 1'b0;
    logic [23:0]      cur_hash = '0;
    logic [CNT_W-1:0] cur_chk = '0;
    logic [CNT_W-1:0] cur_pcnt = '0;

    nonce_verifier #(.BYTE_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .data_in(data_in), .nonce(nonce), .target(target),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .pass(pass),
        .hash_out(hash_out), .checked_cnt(checked_cnt), .pass_cnt(pass_cnt),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [7:0] model_w(input logic [95:0] d, input logic [31:0] n, input int idx);
        logic [7:0] w[32];
        for (int i = 0; i < 12; i++) w[i] = d[95-8*i -: 8];
        for (int i = 0; i < 4; i++) w[12+i] = n[31-8*i -: 8];
        for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        return w[idx];
    endfunction

    function automatic logic [23:0] model_hash(input logic [95:0] d, input logic [31:0] n, input int nr);
        logic [7:0] a, b, c, x, k, na;
        a = 8'h01; b = 8'h89; c = 8'hFE;
        for (int i = 0; i < nr; i++) begin
            if (i <= 16) begin k = 8'h99; x = b ^ c; end
            else begin k = 8'hA1; x = a ^ b; end
            na = c + (x ^ model_w(d, n, i)) + k;
            c = (b >> 2) | (b << 6);
            b = (a << 1) | (a >> 7);
            a = na;
        end
        return {a, b, c};
    endfunction

    function automatic logic model_pass(input logic [23:0] h, input logic [7:0] t);
        return (h[23:16] < t) && (h[15:8] < t);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_pass", pass, 0);
            chk("rst_hash", hash_out, 0);
            chk("rst_checked", checked_cnt, 0);
            chk("rst_pass_cnt", pass_cnt, 0);
        end else if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", resp_valid, 0);
            end else begin
                chk("resp_pass", pass, exp_q[0][EXP_W-1]);
                chk("resp_hash", hash_out, exp_q[0][EXP_W-2 -: 24]);
                chk("resp_checked", checked_cnt, exp_q[0][2*CNT_W-1 -: CNT_W]);
                chk("resp_pass_cnt", pass_cnt, exp_q[0][CNT_W-1:0]);
                if (resp_ready) begin
                    cur_pass = exp_q[0][EXP_W-1];
                    cur_hash = exp_q[0][EXP_W-2 -: 24];
                    cur_chk  = exp_q[0][2*CNT_W-1 -: CNT_W];
                    cur_pcnt = exp_q[0][CNT_W-1:0];
                    void'(exp_q.pop_front());
                end
            end
        end else begin
            chk("hold_pass", pass, cur_pass);
            chk("hold_hash", hash_out, cur_hash);
            chk("hold_checked", checked_cnt, cur_chk);
            chk("hold_pass_cnt", pass_cnt, cur_pcnt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [95:0] d, input logic [31:0] n, input logic [7:0] t);
        logic [23:0] h;
        logic        p;
        int          w;
        req_valid = 1'b1; data_in = d; nonce = n; target = t;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("req_ready_timeout", 1, 0);
        @(posedge clk);
        #1;
        h = model_hash(d, n, 32);
        p = model_pass(h, t);
        if (m_chk < CMAX) m_chk++;
        if (p && m_pcnt < CMAX) m_pcnt++;
        exp_q.push_back({p, h, CNT_W'(m_chk), CNT_W'(m_pcnt)});
        // later input changes must not affect the check in progress
        req_valid = 1'b0;
        data_in = {$urandom, $urandom, $urandom};
        nonce = $urandom;
        target = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_resp();
        int lat;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 33);
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        exp_q.delete();
        m_chk = 0; m_pcnt = 0;
        cur_pass = 1'b0; cur_hash = '0; cur_chk = '0; cur_pcnt = '0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [95:0] gold_d;
        logic [31:0] gold_n;
        logic [31:0] n;
        logic [95:0] seq_d;
        int          found;

        gold_d = 96'h397d9f2f40ca9e6c6b1f3324;
        seq_d  = 96'h000102030405060708090A0B;

        // model pins (hand-computed)
        chk("pin_w16", model_w(seq_d, 32'h0C0D0E0F, 16), 8'h0D);
        chk("pin_w17", model_w(seq_d, 32'h0C0D0E0F, 17), 8'h0F);
        chk("pin_w19", model_w(seq_d, 32'h0C0D0E0F, 19), 8'h0F);
        chk("pin_h_r0", model_hash('0, '0, 0), 24'h0189FE);
        chk("pin_h_r1", model_hash('0, '0, 1), 24'h0E0262);
        chk("pin_h_r2", model_hash('0, '0, 2), 24'h5B1C80);
        chk("pin_pass_lo", model_pass(24'h0F0F00, 8'h10), 1);
        chk("pin_pass_h0", model_pass(24'h100000, 8'h10), 0);
        chk("pin_pass_h1", model_pass(24'h001000, 8'h10), 0);
        chk("pin_pass_t0", model_pass(24'h000000, 8'h00), 0);

        // reset then idle
        apply_reset(3);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_req_ready", req_ready, 1);
        chk("idle_resp_valid", resp_valid, 0);
        chk("idle_checked", checked_cnt, 0);
        chk("idle_hash", hash_out, 0);

        // golden nonce: passes at target 0x10 while nonce+1 fails
        gold_n = '0;
        found = 0;
        for (int i = 0; i < 100000 && found == 0; i++) begin
            if (model_pass(model_hash(gold_d, 32'(i), 32), 8'h10) &&
                !model_pass(model_hash(gold_d, 32'(i + 1), 32), 8'h10)) begin
                gold_n = 32'(i);
                found = 1;
            end
        end
        chk("gold_found", found, 1);

        send_req(gold_d, gold_n, 8'h10);
        wait_resp();
        chk("gold_pass", pass, 1);
        chk("gold_checked", checked_cnt, 1);
        chk("gold_pass_cnt", pass_cnt, 1);

        send_req(gold_d, gold_n + 1, 8'h10);
        wait_resp();
        chk("fail_pass", pass, 0);
        chk("fail_checked", checked_cnt, 2);
        chk("fail_pass_cnt", pass_cnt, 1);

        send_req(gold_d, gold_n, 8'h00);
        wait_resp();
        chk("t0_pass", pass, 0);

        // backpressure: response held, second request stalled
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        send_req(gold_d, gold_n, 8'h10);
        wait_resp();
        req_valid = 1'b1; data_in = seq_d; nonce = 32'h0C0D0E0F; target = 8'hFF;
        repeat (50) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_resp_valid", resp_valid, 1);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        send_req(seq_d, 32'h0C0D0E0F, 8'hFF);
        wait_resp();

        // reset while round 10 is in progress
        @(posedge clk);
        #1;
        send_req(gold_d, gold_n, 8'h10);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_chk = 0; m_pcnt = 0;
        cur_pass = 1'b0; cur_hash = '0; cur_chk = '0; cur_pcnt = '0;
        #1;
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_hash", hash_out, 0);
        chk("mid_rst_checked", checked_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_resp_valid", resp_valid, 0);

        // saturation: 17 passing requests
        n = gold_n;
        for (int r = 1; r <= 17; r++) begin
            found = 0;
            for (int i = 0; i < 100000 && found == 0; i++) begin
                if (model_pass(model_hash(gold_d, n, 32), 8'h10)) found = 1;
                else n = n + 1;
            end
            send_req(gold_d, n, 8'h10);
            wait_resp();
            n = n + 1;
            if (r == 15 || r == 17) begin
                chk("sat_checked", checked_cnt, 15);
                chk("sat_pass_cnt", pass_cnt, 15);
            end
        end

        // random pairs
        for (int r = 0; r < 200; r++) begin
            send_req({$urandom, $urandom, $urandom}, $urandom, 8'($urandom_range(0, 255)));
            wait_resp();
        end

        @(posedge clk);
        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
